mac_sched: RTL
==============

MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one MAC unit.
REQ-002 Parameter DW, default 8, operand width; the result width is 2*DW.
REQ-003 Parameter TMO, default 1023, watchdog limit in cycles (used only when the timeout feature is compiled in).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req  in  NREQ  per-requester request level.
REQ-007 op_a  in  NREQ*DW  packed operand A; requester i occupies slice i.
REQ-008 op_b  in  NREQ*DW  packed operand B; requester i occupies slice i.
REQ-009 gnt  out  NREQ  one-hot grant, held from LOAD through DONE.
REQ-010 done  out  NREQ  one-cycle completion pulse, asserted on the granted bit only.
REQ-011 res  out  2*DW  registered result, valid while done is nonzero and held afterwards.
REQ-012 err  out  1  one-cycle timeout flag, asserted together with done.
REQ-013 mac_a, mac_b  out  DW each  operands driven to the MAC, taken from the granted requester's slices.
REQ-014 stf  out  1  MAC start strobe.
REQ-015 eof  in  1  MAC idle/finished flag; 1 when the MAC is idle.
REQ-016 mac_r  in  2*DW  MAC result.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT_ACK, BUSY and DONE.
REQ-018 IDLE: if req is nonzero, the block SHALL pick a winner by round-robin, starting at ptr+1 and wrapping modulo NREQ, and register gnt; next state LOAD.
REQ-019 LOAD: stf=1 for exactly this one cycle; next state WAIT_ACK.
REQ-020 WAIT_ACK: on eof=0, next state BUSY; otherwise stay.
REQ-021 BUSY: on eof=1, capture mac_r into res; next state DONE.
REQ-022 DONE: done = gnt for one cycle; ptr gets the winner index; next state IDLE, and gnt clears on entry to IDLE.
REQ-023 Latency: req seen in IDLE at cycle k gives stf at k+1; done is asserted 1 cycle after eof returns high.
REQ-024 mac_a and mac_b SHALL be a combinational mux on the registered grant, stable from LOAD through DONE; requesters hold their operands until done.
REQ-025 req SHALL be sampled only in IDLE; deasserting req after grant SHALL NOT abort the operation, and the result is still delivered.
REQ-026 All requesters asserted simultaneously: grants SHALL rotate, with no requester served twice before every other active requester has been served once.
REQ-027 A requester re-asserting req in its own DONE cycle SHALL lose to any other pending requester at the next IDLE.
REQ-028 stf, done and err SHALL be 0 in every state not named above for them.

Reset
REQ-029 On rst: state=IDLE, gnt=0, done=0, stf=0, err=0, res=0, and ptr=NREQ-1 (requester 0 has first priority).
REQ-030 rst asserted mid-operation SHALL abort immediately with no done pulse; the MAC shares the same rst.

Configuration
REQ-031 Macro MAC_SCHED_TIMEOUT_EN defined: a counter SHALL clear in LOAD and count in WAIT_ACK and BUSY; on reaching TMO the FSM SHALL go to DONE with err=1, leaving res unchanged.
REQ-032 Macro MAC_SCHED_TIMEOUT_EN undefined: no counter is built, err is tied to 0, and TMO is unused.

Structure
REQ-033 Package mac_sched_pkg SHALL hold the state enum, the default NREQ/DW/TMO constants and the index width function.
REQ-034 Sub-module rr_arbiter (inputs: req, ptr; outputs: one-hot winner, winner index) SHALL be purely combinational and instantiated once.

Verification
REQ-035 Single requester: after reset, req=0100, op_a[2]=5, op_b[2]=3 -> gnt=0100, stf pulses once, done=0100, res=15.
REQ-036 Full contention: req=1111 held -> grant order 0,1,2,3,0 with one done per operation.
REQ-037 Early release: req[1] drops during BUSY -> done[1] is still pulsed and res is correct.
REQ-038 Back-to-back: requester 0 re-requests in its DONE cycle while req[3]=1 -> the next grant is 1000.
REQ-039 Reset mid-op: rst pulsed during BUSY -> gnt=0, no done, the next request is served normally.
REQ-040 With MAC_SCHED_TIMEOUT_EN, TMO=20 and eof held at 0 -> done and err pulse 20 cycles after WAIT_ACK entry, and res keeps its previous value.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// Shared types and defaults for the MAC scheduler: FSM states, parameter defaults and
// the index-width helper used to size the round-robin pointer.
package mac_sched_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned TMO_DEF  = 1023;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitAck,
    StBusy,
    StDone
  } state_e;

  // Width of an index into n requesters, never less than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upwards, wrapping modulo NREQ,
// and returns the first requester found as a one-hot vector plus its index.
module rr_arbiter import mac_sched_pkg::*; #(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  logic found;

  // Outer loop is the distance from ptr, so the first hit is the nearest requester.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!found && req[i] && (ptr == IW'((i + int'(NREQ) - k) % int'(NREQ)))) begin
          found   = 1'b1;
          win[i]  = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mac_sched.sv
// Schedules NREQ requesters onto one shared MAC unit with round-robin fairness.
// Optional watchdog when MAC_SCHED_TIMEOUT_EN is defined.
module mac_sched import mac_sched_pkg::*; #(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned TMO  = TMO_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] op_a,
  input  logic [NREQ*DW-1:0] op_b,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [2*DW-1:0]    res,
  output logic               err,
  output logic [DW-1:0]      mac_a,
  output logic [DW-1:0]      mac_b,
  output logic               stf,
  input  logic               eof,
  input  logic [2*DW-1:0]    mac_r
);

  localparam int unsigned IW = idx_w(NREQ);

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       win_q, win_d;
  logic [2*DW-1:0]     res_q, res_d;
  logic [NREQ-1:0]     arb_win;
  logic [IW-1:0]       arb_idx;
  logic                tmo_hit;
  logic                tmo_fire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win     (arb_win),
    .win_idx (arb_idx)
  );

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_q[i]) begin
        mac_a = mac_a | op_a[i*DW +: DW];
        mac_b = mac_b | op_b[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    res_d    = res_q;
    stf      = 1'b0;
    done     = '0;
    tmo_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = arb_win;
          win_d   = arb_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        stf     = 1'b1;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = StDone;
        end else if (!eof) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        // A genuine completion wins over a coincident watchdog expiry.
        if (eof) begin
          res_d   = mac_r;
          state_d = StDone;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        done    = gnt_q;
        ptr_d   = win_q;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      win_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      res_q   <= res_d;
    end
  end

  assign gnt = gnt_q;
  assign res = res_q;

`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StLoad) begin
        cnt_q <= '0;
      end else if (state_q == StWaitAck || state_q == StBusy) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == StLoad) begin
        err_q <= 1'b0;
      end else if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tmo_hit = (cnt_q == CW'(TMO - 1));
  assign err     = (state_q == StDone) && err_q;
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
  assign unused_tmo = ^{TMO, tmo_fire};
`endif

endmodule
